// File: rtl/gpio_cmd_master.sv
// gpio_cmd_master: initiator for the GPIO command protocol (setup/strobe/gap, read-back, start/end-of-process).
// Optional RUN_WAIT watchdog with sticky o_timeout: define GPIO_MASTER_TIMEOUT_EN.
module gpio_cmd_master #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 2,
    parameter int unsigned GAP_CYC     = 2,
`ifdef GPIO_MASTER_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYC = 1048575,
`endif
    parameter int unsigned READ_LAT    = 2
) (
    input  logic        i_CLK,
    input  logic        i_rst,
    input  logic        i_cmdValid,
    input  logic [2:0]  i_cmdCode,
    input  logic [23:0] i_cmdData,
    output logic        o_cmdReady,
    output logic        o_cmdErr,
    output logic        o_GPIOvalid,
    output logic [2:0]  o_GPIOctrl,
    output logic [23:0] o_GPIOdata,
    input  logic [31:0] i_GPIOdata,
    input  logic        i_EoP,
    output logic        o_rspValid,
    output logic [31:0] o_rspData,
    output logic        o_busy,
`ifdef GPIO_MASTER_TIMEOUT_EN
    output logic        o_timeout,
`endif
    output logic        o_done
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned RSP_W  = 32;

    localparam logic [CODE_W-1:0] CTRL_PARK = CODE_W'(3);
    localparam logic [CODE_W-1:0] CODE_READ = CODE_W'(3);
    localparam logic [CODE_W-1:0] CODE_RUN  = CODE_W'(4);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_GAP, S_RUN_WAIT, S_READ_WAIT
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               eop_q;
    logic               eop_rise;
    logic               accept;
    logic               cmd_legal;
    logic               phase_end;

    logic               valid_nxt;
    logic [CODE_W-1:0]  ctrl_nxt;
    logic [DATA_W-1:0]  data_nxt;
    logic               rsp_valid_nxt;
    logic [RSP_W-1:0]   rsp_data_nxt;
    logic               err_nxt;
    logic               done_nxt;

`ifdef GPIO_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = 20;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               tmo_hit;
    logic               timeout_nxt;

    assign tmo_hit = (state == S_RUN_WAIT) && !eop_rise
                     && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`endif

    assign accept    = i_cmdValid && (state == S_IDLE);
    assign cmd_legal = (i_cmdCode <= CODE_RUN);
    assign eop_rise  = i_EoP && !eop_q;

    // State, phase counter, EoP edge register and all registered outputs
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            eop_q       <= 1'b0;
            o_cmdReady  <= 1'b1;
            o_cmdErr    <= 1'b0;
            o_GPIOvalid <= 1'b0;
            o_GPIOctrl  <= CTRL_PARK;
            o_GPIOdata  <= '0;
            o_rspValid  <= 1'b0;
            o_rspData   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
`ifdef GPIO_MASTER_TIMEOUT_EN
            tmo_cnt     <= '0;
            o_timeout   <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
            eop_q       <= i_EoP;
            o_cmdReady  <= (state_nxt == S_IDLE);
            o_cmdErr    <= err_nxt;
            o_GPIOvalid <= valid_nxt;
            o_GPIOctrl  <= ctrl_nxt;
            o_GPIOdata  <= data_nxt;
            o_rspValid  <= rsp_valid_nxt;
            o_rspData   <= rsp_data_nxt;
            o_busy      <= (state_nxt != S_IDLE);
            o_done      <= done_nxt;
`ifdef GPIO_MASTER_TIMEOUT_EN
            tmo_cnt     <= (state == S_RUN_WAIT && state_nxt == S_RUN_WAIT) ? tmo_cnt + TMO_W'(1) : '0;
            o_timeout   <= timeout_nxt;
`endif
        end
    end

    // Next-state logic; a start-process command is recognised in SETUP by its ctrl code
    always_comb begin
        state_nxt = state;
        phase_end = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept && cmd_legal)
                    state_nxt = (i_cmdCode == CODE_READ) ? S_READ_WAIT : S_SETUP;
            end
            S_SETUP: begin
                phase_end = (cnt == CNT_W'(SETUP_CYC - 1));
                if (phase_end)
                    state_nxt = (o_GPIOctrl == CODE_RUN) ? S_RUN_WAIT : S_STROBE;
            end
            S_STROBE: begin
                phase_end = (cnt == CNT_W'(STROBE_CYC - 1));
                if (phase_end) state_nxt = S_GAP;
            end
            S_GAP: begin
                phase_end = (cnt == CNT_W'(GAP_CYC - 1));
                if (phase_end) state_nxt = S_IDLE;
            end
            S_READ_WAIT: begin
                phase_end = (cnt == CNT_W'(READ_LAT - 1));
                if (phase_end) state_nxt = S_IDLE;
            end
            S_RUN_WAIT: begin
                if (eop_rise) state_nxt = S_IDLE;
`ifdef GPIO_MASTER_TIMEOUT_EN
                if (tmo_hit) state_nxt = S_IDLE;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        valid_nxt     = (state_nxt == S_STROBE);
        ctrl_nxt      = o_GPIOctrl;
        data_nxt      = o_GPIOdata;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = o_rspData;
        err_nxt       = 1'b0;
        done_nxt      = 1'b0;
        if (accept) begin
            if (cmd_legal) begin
                ctrl_nxt = i_cmdCode;
                data_nxt = i_cmdData;
            end else begin
                err_nxt = 1'b1;
            end
        end
        // Park whenever no command is driving the slave
        if (state != S_IDLE && (state_nxt == S_IDLE || state_nxt == S_RUN_WAIT))
            ctrl_nxt = CTRL_PARK;
        if (state == S_READ_WAIT && state_nxt == S_IDLE) begin
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = i_GPIOdata;
        end
        if (state == S_RUN_WAIT && eop_rise)
            done_nxt = 1'b1;
`ifdef GPIO_MASTER_TIMEOUT_EN
        timeout_nxt = o_timeout | tmo_hit;
`endif
    end

endmodule

// File: tb/tb_gpio_cmd_master.sv
// Bench for gpio_cmd_master: random and directed commands checked against a transaction-level timing model.
// Build with GPIO_MASTER_TIMEOUT_EN defined to also exercise the RUN_WAIT watchdog.
module tb_gpio_cmd_master;

    localparam int unsigned SETUP_CYC  = 1;
    localparam int unsigned STROBE_CYC = 2;
    localparam int unsigned GAP_CYC    = 2;
    localparam int unsigned READ_LAT   = 2;
    localparam int unsigned WR_LEN     = SETUP_CYC + STROBE_CYC + GAP_CYC;
`ifdef GPIO_MASTER_TIMEOUT_EN
    localparam int unsigned TIMEOUT_CYC = 50;
    localparam int unsigned RUN_DLY     = 40;
`else
    localparam int unsigned RUN_DLY     = 100;
`endif

    logic        i_CLK = 1'b0;
    logic        i_rst;
    logic        i_cmdValid;
    logic [2:0]  i_cmdCode;
    logic [23:0] i_cmdData;
    logic        o_cmdReady;
    logic        o_cmdErr;
    logic        o_GPIOvalid;
    logic [2:0]  o_GPIOctrl;
    logic [23:0] o_GPIOdata;
    logic [31:0] i_GPIOdata;
    logic        i_EoP;
    logic        o_rspValid;
    logic [31:0] o_rspData;
    logic        o_busy;
    logic        o_done;
`ifdef GPIO_MASTER_TIMEOUT_EN
    logic        o_timeout;
`endif

    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    int          acc_cyc    = 0;
    int          rises      = 0;
    logic        v_q        = 1'b0;

    // Model of the values the DUT must be holding between commands
    logic [23:0] exp_data;
    logic [31:0] exp_rsp;
    logic        exp_timeout;

    gpio_cmd_master #(
        .SETUP_CYC  (SETUP_CYC),
        .STROBE_CYC (STROBE_CYC),
        .GAP_CYC    (GAP_CYC),
`ifdef GPIO_MASTER_TIMEOUT_EN
        .TIMEOUT_CYC(TIMEOUT_CYC),
`endif
        .READ_LAT   (READ_LAT)
    ) dut (
        .i_CLK      (i_CLK),
        .i_rst      (i_rst),
        .i_cmdValid (i_cmdValid),
        .i_cmdCode  (i_cmdCode),
        .i_cmdData  (i_cmdData),
        .o_cmdReady (o_cmdReady),
        .o_cmdErr   (o_cmdErr),
        .o_GPIOvalid(o_GPIOvalid),
        .o_GPIOctrl (o_GPIOctrl),
        .o_GPIOdata (o_GPIOdata),
        .i_GPIOdata (i_GPIOdata),
        .i_EoP      (i_EoP),
        .o_rspValid (o_rspValid),
        .o_rspData  (o_rspData),
        .o_busy     (o_busy),
`ifdef GPIO_MASTER_TIMEOUT_EN
        .o_timeout  (o_timeout),
`endif
        .o_done     (o_done)
    );

    always #5 i_CLK = ~i_CLK;

    always @(posedge i_CLK) cyc++;

    // Count strobe rising edges seen by the slave
    always @(negedge i_CLK) begin
        if (o_GPIOvalid && !v_q) rises++;
        v_q = o_GPIOvalid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string ph, input logic ev, input logic [2:0] ec,
                                 input logic eb, input logic ee, input logic er, input logic ed);
        check({ph, ".valid"},   32'(o_GPIOvalid), 32'(ev));
        check({ph, ".ctrl"},    32'(o_GPIOctrl),  32'(ec));
        check({ph, ".data"},    32'(o_GPIOdata),  32'(exp_data));
        check({ph, ".ready"},   32'(o_cmdReady),  32'(!eb));
        check({ph, ".busy"},    32'(o_busy),      32'(eb));
        check({ph, ".err"},     32'(o_cmdErr),    32'(ee));
        check({ph, ".rspv"},    32'(o_rspValid),  32'(er));
        check({ph, ".rspdata"}, o_rspData,        exp_rsp);
        check({ph, ".done"},    32'(o_done),      32'(ed));
`ifdef GPIO_MASTER_TIMEOUT_EN
        check({ph, ".timeout"}, 32'(o_timeout),   32'(exp_timeout));
`endif
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge i_CLK); #1;
            check_outputs("idle", 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Present one command, wait for acceptance, then check every cycle until the DUT is idle again.
    // Optionally presents the following command while this one is still busy.
    task automatic send(input logic [2:0] code, input logic [23:0] payload,
                        input logic has_next, input logic [2:0] ncode, input logic [23:0] ndata,
                        input int unsigned eop_dly, input logic rand_gd);
        int unsigned waited = 0;
        logic [31:0] gd_prev;
        i_cmdValid = 1'b1;
        i_cmdCode  = code;
        i_cmdData  = payload;
        while (!o_cmdReady) begin
            if (waited == 64) begin
                check("accept_wait", 32'(o_cmdReady), 32'd1);
                i_cmdValid = 1'b0;
                return;
            end
            @(posedge i_CLK); #1;
            waited++;
        end
        @(posedge i_CLK); #1;
        acc_cyc = cyc;
        if (has_next) begin
            i_cmdCode = ncode;
            i_cmdData = ndata;
        end else begin
            i_cmdValid = 1'b0;
        end
        if (code <= 3'd4) exp_data = payload;

        if (code <= 3'd2) begin
            for (int unsigned j = 0; j <= WR_LEN; j++) begin
                if (j > 0) begin @(posedge i_CLK); #1; end
                check_outputs("write", (j >= SETUP_CYC) && (j < SETUP_CYC + STROBE_CYC),
                              (j < WR_LEN) ? code : 3'd3, j < WR_LEN, 1'b0, 1'b0, 1'b0);
            end
        end else if (code == 3'd3) begin
            gd_prev = i_GPIOdata;
            for (int unsigned j = 0; j <= READ_LAT; j++) begin
                if (j > 0) begin @(posedge i_CLK); #1; end
                if (j == READ_LAT) exp_rsp = gd_prev;
                check_outputs("read", 1'b0, 3'd3, j < READ_LAT, 1'b0, j == READ_LAT, 1'b0);
                if (rand_gd) begin
                    gd_prev    = $urandom;
                    i_GPIOdata = gd_prev;
                end
            end
        end else if (code == 3'd4) begin
            for (int unsigned j = 0; j <= eop_dly; j++) begin
                if (j > 0) begin @(posedge i_CLK); #1; end
                check_outputs("run", 1'b0, (j < SETUP_CYC) ? 3'd4 : 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
            end
            i_EoP = 1'b1;
            @(posedge i_CLK); #1;
            check_outputs("run_done", 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
            i_EoP = 1'b0;
        end else begin
            check_outputs("err", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [23:0] px [4];
        logic [2:0]  rc;
        int          prev;
        int          r0;

        i_rst = 1'b1; i_cmdValid = 1'b0; i_cmdCode = '0; i_cmdData = '0;
        i_GPIOdata = '0; i_EoP = 1'b0;
        exp_data = '0; exp_rsp = '0; exp_timeout = 1'b0;
        repeat (3) @(posedge i_CLK);
        #1;
        check_outputs("reset", 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        i_rst = 1'b0;
        idle(2);

        // Kernel load
        r0 = rises;
        send(3'd0, 24'h123456, 1'b0, 3'd0, 24'd0, 0, 1'b0);
        check("kernel_rises", 32'(rises - r0), 32'd1);
        idle(2);

        // Image size then 4 pixels, each presented while the previous one is busy
        for (int i = 0; i < 4; i++) px[i] = 24'($urandom);
        r0 = rises;
        send(3'd1, 24'd512, 1'b1, 3'd2, px[0], 0, 1'b0);
        prev = acc_cyc;
        for (int i = 0; i < 4; i++) begin
            send(3'd2, px[i], i < 3, 3'd2, (i < 3) ? px[(i + 1) % 4] : 24'd0, 0, 1'b0);
            check("burst_spacing", 32'(acc_cyc - prev), 32'(WR_LEN + 1));
            prev = acc_cyc;
        end
        check("burst_rises", 32'(rises - r0), 32'd5);
        idle(1);

        // Start process with late end-of-process
        send(3'd4, 24'h00BEEF, 1'b0, 3'd0, 24'd0, RUN_DLY, 1'b0);
        idle(2);

        // Read-back of a fixed word, no strobe
        r0 = rises;
        i_GPIOdata = 32'h0000_1ABC;
        send(3'd3, 24'h000777, 1'b0, 3'd0, 24'd0, 0, 1'b0);
        check("read_rises", 32'(rises - r0), 32'd0);
        check("read_word", o_rspData, 32'h0000_1ABC);
        idle(1);

        // Illegal code
        send(3'd6, 24'hFFFFFF, 1'b0, 3'd0, 24'd0, 0, 1'b0);
        idle(1);

        // EoP rising while idle is ignored
        i_EoP = 1'b1;
        idle(2);
        i_EoP = 1'b0;
        idle(1);

        // Random command stream
        for (int n = 0; n < 40; n++) begin
            rc = 3'($urandom_range(0, 7));
            r0 = rises;
            send(rc, 24'($urandom), 1'b0, 3'd0, 24'd0, $urandom_range(1, 30), 1'b1);
            check("rand_rises", 32'(rises - r0), (rc <= 3'd2) ? 32'd1 : 32'd0);
            idle($urandom_range(1, 3));
        end

        // Reset mid-strobe, with cmdValid held through the reset cycle
        i_cmdValid = 1'b1; i_cmdCode = 3'd0; i_cmdData = 24'hABCDEF;
        @(posedge i_CLK); #1;
        exp_data = 24'hABCDEF;
        check_outputs("pre_rst_setup", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge i_CLK); #1;
        check_outputs("pre_rst_strobe", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        i_rst = 1'b1;
        @(posedge i_CLK); #1;
        i_rst = 1'b0; i_cmdValid = 1'b0;
        exp_data = '0; exp_rsp = '0; exp_timeout = 1'b0;
        check_outputs("rst_mid", 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

`ifdef GPIO_MASTER_TIMEOUT_EN
        // Watchdog: no EoP at all
        i_cmdValid = 1'b1; i_cmdCode = 3'd4; i_cmdData = 24'h000042;
        @(posedge i_CLK); #1;
        i_cmdValid = 1'b0;
        exp_data = 24'h000042;
        for (int unsigned j = 0; j <= TIMEOUT_CYC + 2; j++) begin
            if (j > 0) begin @(posedge i_CLK); #1; end
            exp_timeout = (j > TIMEOUT_CYC);
            check_outputs("tmo", 1'b0, (j < SETUP_CYC) ? 3'd4 : 3'd3, j <= TIMEOUT_CYC,
                          1'b0, 1'b0, 1'b0);
        end
        i_rst = 1'b1;
        @(posedge i_CLK); #1;
        i_rst = 1'b0;
        exp_data = '0; exp_timeout = 1'b0;
        check_outputs("tmo_clear", 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
